therm_adc_reader: RTL and testbench

THERM_ADC_READER -- requirements
Module: therm_adc_reader

---
 rtl/therm_pkg.sv | 24 ++
 rtl/spi_adc_frame.sv | 72 +++++++
 rtl/therm_adc_reader.sv | 107 ++++++++++
 tb/tb_therm_adc_reader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/therm_pkg.sv
// Shared constants, FSM encoding and code-to-millivolt scaling for the
// thermistor ADC reader.
package therm_pkg;

  localparam int VREF_MV    = 3300;
  localparam int ADC_BITS   = 12;
  localparam int FRAME_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    FRAME,
    ACC,
    GAP,
    OUT
  } state_t;

  // Scale an averaged ADC code to millivolts, truncating.
  function automatic logic [31:0] code_to_mv(input logic [ADC_BITS-1:0] avg);
    logic [31:0] prod;
    prod = 32'(avg) * 32'(VREF_MV);
    return prod >> ADC_BITS;
  endfunction

endpackage

// File: rtl/spi_adc_frame.sv
// One 16-bit SPI read frame: SCLK divider, edge counter and MSB-first shift
// register; start launches a frame, done pulses with the 12-bit code.
module spi_adc_frame
  import therm_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                miso,
  output logic                cs_n,
  output logic                sclk,
  output logic                done,
  output logic [ADC_BITS-1:0] code
);

  localparam int EDGES = 2 * FRAME_BITS;

  logic                  busy;
  logic                  tail;
  logic [7:0]            div_cnt;
  logic [5:0]            edge_cnt;
  logic [FRAME_BITS-1:0] shift;
  logic                  tick;

  assign tick = busy && (div_cnt == 8'(CLK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      tail     <= 1'b0;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      done     <= 1'b0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      shift    <= '0;
      code     <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy && !tail) begin
        busy     <= 1'b1;
        cs_n     <= 1'b0;
        div_cnt  <= '0;
        edge_cnt <= '0;
      end else if (busy) begin
        if (tick) begin
          div_cnt  <= '0;
          sclk     <= ~sclk;
          edge_cnt <= edge_cnt + 6'd1;
          // Low-to-high SCLK transition is the sampling edge.
          if (!sclk) shift <= {shift[FRAME_BITS-2:0], miso};
          if (edge_cnt == 6'(EDGES - 1)) begin
            busy <= 1'b0;
            tail <= 1'b1;
          end
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end else if (tail) begin
        tail <= 1'b0;
        cs_n <= 1'b1;
        done <= 1'b1;
        code <= shift[ADC_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/therm_adc_reader.sv
// Thermistor ADC reader: frames the SPI ADC, averages 2^AVG_LOG2 codes and
// reports millivolts. Optional range fault: define THERM_ADC_RANGE_CHECK_EN.
module therm_adc_reader
  import therm_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int AVG_LOG2   = 3,
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        adc_miso,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [31:0] v_therm,
  output logic        v_valid,
  output logic        fault
);

  localparam int ACC_W = ADC_BITS + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

  state_t               state, state_nx;
  logic                 frame_start, frame_done;
  logic [ADC_BITS-1:0]  code;
  logic [ACC_W-1:0]     acc, acc_sum;
  logic [CNT_W-1:0]     cnt;
  logic [15:0]          gap_cnt;
  logic                 gap_end, batch_full;
  logic                 acc_en, load_out, clr;

  spi_adc_frame #(.CLK_DIV(CLK_DIV)) u_frame (
    .clk   (clk),
    .rst   (rst),
    .start (frame_start),
    .miso  (adc_miso),
    .cs_n  (adc_cs_n),
    .sclk  (adc_sclk),
    .done  (frame_done),
    .code  (code)
  );

  assign gap_end    = (gap_cnt == 16'(GAP_CYCLES - 1));
  assign batch_full = (cnt == LAST_CNT);
  assign acc_sum    = acc + ACC_W'(code);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: default assignment first so no path leaves state_nx unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = FRAME;
      FRAME:   if (frame_done) state_nx = ACC;
      ACC:     state_nx = batch_full ? OUT : GAP;
      OUT:     state_nx = GAP;
      GAP:     if (gap_end) state_nx = en ? FRAME : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    frame_start = (state_nx == FRAME) && (state != FRAME);
    acc_en      = (state == ACC);
    load_out    = (state == ACC) && batch_full;
    clr         = (state == OUT);
  end

  // Result and pulse are registered out of ACC so both are visible in OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
      v_therm <= '0;
      v_valid <= 1'b0;
    end else begin
      v_valid <= load_out;
      if (acc_en) begin
        acc <= acc_sum;
        cnt <= cnt + 1'b1;
      end
      if (load_out) v_therm <= code_to_mv(ADC_BITS'(acc_sum >> AVG_LOG2));
      if (clr) begin
        acc <= '0;
        cnt <= '0;
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
    end
  end

`ifdef THERM_ADC_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                                    fault <= 1'b0;
    else if (acc_en && (code == '0 || code == '1)) fault <= 1'b1;
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_therm_adc_reader.sv
// Scoreboard bench: two readers (AVG_LOG2=3 and 0) fed by behavioural ADC
// models; expected voltages are queued per batch and checked on v_valid.
module tb_therm_adc_reader;

  localparam int CLK_DIV = 4;
  localparam int GAP     = 16;

  typedef struct {
    logic [31:0] mv;
    int unsigned at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  int          mode = 0;
  logic [11:0] const_code = 12'd2048;
  int          epoch = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : ch
    localparam int L = (g == 0) ? 3 : 0;

    logic        cs_n, sclk, miso, fault, v_valid;
    logic [31:0] v_therm;

    therm_adc_reader #(.CLK_DIV(CLK_DIV), .AVG_LOG2(L), .GAP_CYCLES(GAP)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .adc_miso (miso),
      .adc_cs_n (cs_n),
      .adc_sclk (sclk),
      .v_therm  (v_therm),
      .v_valid  (v_valid),
      .fault    (fault)
    );

    logic [15:0] word = '0;
    int          bitn = 0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    int          rise_cnt = 0;
    int unsigned t_fall = 0, t_rise = 0;
    int          sum = 0, n = 0, frames = 0, valids = 0;
    int          seen_epoch = -1;
    logic        alt = 1'b0;
    logic        fault_exp = 1'b0;
    exp_t        q[$];
    exp_t        e;
    logic [11:0] code;
    int          r;

    assign miso = word[bitn];

    always @(negedge clk) begin
      if (v_valid) begin
        valids++;
        if (q.size() == 0) check("unexpected_v_valid", 1, 0);
        else begin
          e = q.pop_front();
          check("v_therm", v_therm, e.mv);
          check("valid_latency", cyc - e.at, 2);
          check("fault_at_valid", {31'd0, fault}, {31'd0, fault_exp});
        end
      end
      if (rst) begin
        q.delete();
        sum = 0; n = 0; rise_cnt = 0; fault_exp = 1'b0;
      end else begin
        if (prev_cs && !cs_n) begin
          if (g == 1) code = 12'd4095;
          else begin
            if (epoch != seen_epoch) begin seen_epoch = epoch; alt = 1'b0; end
            case (mode)
              0: code = const_code;
              1: begin code = alt ? 12'd3000 : 12'd1000; alt = ~alt; end
              default: begin
                r = $urandom_range(0, 9);
                code = (r == 0) ? 12'd0 : (r == 1) ? 12'd4095 : 12'($urandom_range(0, 4095));
              end
            endcase
          end
          word = {4'($urandom), code};
          bitn = 15; rise_cnt = 0; t_fall = cyc;
        end
        if (!cs_n && !prev_sclk && sclk) begin
          rise_cnt++;
          if (rise_cnt == 1) check("first_rise_delay", cyc - t_fall, CLK_DIV);
          else               check("sclk_period", cyc - t_rise, 2 * CLK_DIV);
          t_rise = cyc;
        end
        if (!cs_n && prev_sclk && !sclk && bitn > 0) bitn--;
        if (!prev_cs && cs_n) begin
          check("rises_per_frame", rise_cnt, 16);
          check("cs_low_129_130", {31'd0, (cyc - t_fall >= 129) && (cyc - t_fall <= 130)}, 1);
          if (rise_cnt == 16) begin
            code = word[11:0];
            sum += int'(code);
            n++; frames++;
`ifdef THERM_ADC_RANGE_CHECK_EN
            if (code == 12'd0 || code == 12'd4095) fault_exp = 1'b1;
`endif
            if (n == (1 << L)) begin
              e.mv = ((sum / (1 << L)) * 3300) / 4096;
              e.at = cyc;
              q.push_back(e);
              sum = 0; n = 0;
            end
          end
        end
      end
      prev_cs   = cs_n;
      prev_sclk = sclk;
    end
  end

  task automatic wait_valid(input int budget);
    int v0;
    v0 = ch[0].valids;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (ch[0].valids != v0) return;
    end
    check("timeout_wait_valid", 0, 1);
  endtask

  task automatic set_mode(input int m, input logic [11:0] c);
    mode = m; const_code = c; epoch++;
  endtask

  initial begin
    int  f0, v0;
    bit  hit;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", ch[0].cs_n, 1);
    check("rst_sclk", ch[0].sclk, 0);
    check("rst_v_therm", ch[0].v_therm, 0);
    check("rst_v_valid", ch[0].v_valid, 0);
    check("rst_fault", ch[0].fault, 0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("idle_without_en", ch[0].cs_n, 1);

    // Constant 2048: 1650 mV, one pulse per 8 frames.
    set_mode(0, 12'd2048);
    en = 1'b1;
    wait_valid(3000);
    #1 check("v_therm_2048", ch[0].v_therm, 1650);
    f0 = ch[0].frames;
    wait_valid(3000);
    #1 check("v_therm_2048_b2", ch[0].v_therm, 1650);
    check("frames_per_valid", ch[0].frames - f0, 8);
    check("v_therm_4095_avg0", ch[1].v_therm, 3299);
`ifdef THERM_ADC_RANGE_CHECK_EN
    check("fault_4095", ch[1].fault, 1);
`else
    check("fault_tied_low", ch[1].fault, 0);
`endif

    set_mode(1, 12'd0);
    wait_valid(3000);
    #1 check("v_therm_alt", ch[0].v_therm, 1611);
    wait_valid(3000);
    #1 check("v_therm_alt_b2", ch[0].v_therm, 1611);

    set_mode(2, 12'd0);
    repeat (3) wait_valid(3000);

    // Reset at 7th SCLK rise, after a partial batch of 4095 codes.
    set_mode(0, 12'd4095);
    f0 = ch[0].frames;
    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(posedge clk);
      hit = (ch[0].frames >= f0 + 2) && !ch[0].cs_n && (ch[0].rise_cnt == 7);
    end
    check("reached_7th_rise", {31'd0, hit}, 1);
    #1 rst = 1'b1;
    set_mode(0, 12'd2048);
    @(posedge clk);
    #1;
    check("midframe_rst_cs_n", ch[0].cs_n, 1);
    check("midframe_rst_sclk", ch[0].sclk, 0);
    check("midframe_rst_v_therm", ch[0].v_therm, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_valid(3000);
    #1 check("first_batch_after_rst", ch[0].v_therm, 1650);

    // Drop en during frame 3 of 8.
    set_mode(2, 12'd0);
    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(posedge clk);
      hit = (ch[0].n == 2) && !ch[0].cs_n && (ch[0].rise_cnt >= 2);
    end
    check("reached_frame3", {31'd0, hit}, 1);
    #1 en = 1'b0;
    f0 = ch[0].frames;
    v0 = ch[0].valids;
    repeat (600) @(posedge clk);
    #1;
    check("frame3_completed", ch[0].frames - f0, 1);
    check("no_valid_while_idle", ch[0].valids - v0, 0);
    check("idle_cs_n_high", ch[0].cs_n, 1);
    en = 1'b1;
    f0 = ch[0].frames;
    wait_valid(3000);
    check("frames_after_reenable", ch[0].frames - f0, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
